ps_cu_issue: RTL and testbench

//  Program-sequencer-side issue unit that drives the compute unit control interface (crossbar, regfile, multiplier, shifter).

---
 rtl/ps_cu_issue.sv | 245 ++++++++++++++++++++++++
 tb/tb_ps_cu_issue.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ps_cu_issue.sv
// Issue unit: sequences one decoded compute/DM-load instruction at a time onto
// the compute unit control interface and keeps sticky multiplier/shifter flags.
module ps_cu_issue #(
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned SIGNAL_WIDTH  = 3,
    parameter int unsigned MUL_LAT       = 2,
    parameter int unsigned SHF_LAT       = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [9+3*ADDRESS_WIDTH-1:0] in_instr,
    input  logic                         clr_flags,
    output logic [ADDRESS_WIDTH-1:0]     ps_rf_xA,
    output logic [ADDRESS_WIDTH-1:0]     ps_rf_yA,
    output logic [ADDRESS_WIDTH-1:0]     ps_rf_wrtA,
    output logic [SIGNAL_WIDTH-1:0]      ps_xb_cuEn,
    output logic                         ps_xb_dmEn,
    output logic                         ps_mul_en,
    output logic                         ps_mul_otreg,
    output logic [3:0]                   ps_mul_dtsts,
    output logic [1:0]                   ps_mul_cls,
    output logic                         ps_shf_en,
    output logic [1:0]                   ps_shf_cls,
    input  logic                         mul_ps_ov,
    input  logic                         mul_ps_mn,
    input  logic                         shf_ovflag,
    input  logic                         shf_zeroflag,
    output logic                         sts_mv,
    output logic                         sts_mn,
    output logic                         sts_sv,
    output logic                         sts_sz,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned AW      = ADDRESS_WIDTH;
    localparam int unsigned SW      = SIGNAL_WIDTH;
    localparam int unsigned INSTR_W = 9 + 3 * AW;
    localparam int unsigned CNT_W   = 8;

    // Field positions inside the instruction word {unit,cls,dtsts,otreg,rn,rx,ry}
    localparam int unsigned RY_LSB    = 0;
    localparam int unsigned RX_LSB    = AW;
    localparam int unsigned RN_LSB    = 2 * AW;
    localparam int unsigned OTREG_BIT = 3 * AW;
    localparam int unsigned DTSTS_LSB = 3 * AW + 1;
    localparam int unsigned CLS_LSB   = 3 * AW + 5;
    localparam int unsigned UNIT_LSB  = 3 * AW + 7;

    localparam logic [1:0] UNIT_ALU = 2'b00;
    localparam logic [1:0] UNIT_MUL = 2'b01;
    localparam logic [1:0] UNIT_SHF = 2'b10;
    localparam logic [1:0] UNIT_DM  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [AW-1:0]        xa_q, xa_d, ya_q, ya_d, wa_q, wa_d;
    logic [SW-1:0]        cuen_q, cuen_d;
    logic                 dmen_q, dmen_d;
    logic                 mul_en_q, mul_en_d, mul_otreg_q, mul_otreg_d;
    logic [3:0]           mul_dtsts_q, mul_dtsts_d;
    logic [1:0]           mul_cls_q, mul_cls_d;
    logic                 shf_en_q, shf_en_d;
    logic [1:0]           shf_cls_q, shf_cls_d;
    logic                 mv_q, mv_d, mn_q, mn_d, sv_q, sv_d, sz_q, sz_d;

    logic [1:0]           unit_q, unit_d, in_unit;

    assign unit_q  = instr_q[UNIT_LSB +: 2];
    assign unit_d  = instr_d[UNIT_LSB +: 2];
    assign in_unit = in_instr[UNIT_LSB +: 2];

    // State, latched instruction, counter, registered outputs and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            xa_q        <= '0;
            ya_q        <= '0;
            wa_q        <= '0;
            cuen_q      <= '0;
            dmen_q      <= 1'b0;
            mul_en_q    <= 1'b0;
            mul_otreg_q <= 1'b0;
            mul_dtsts_q <= '0;
            mul_cls_q   <= '0;
            shf_en_q    <= 1'b0;
            shf_cls_q   <= '0;
            mv_q        <= 1'b0;
            mn_q        <= 1'b0;
            sv_q        <= 1'b0;
            sz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            xa_q        <= xa_d;
            ya_q        <= ya_d;
            wa_q        <= wa_d;
            cuen_q      <= cuen_d;
            dmen_q      <= dmen_d;
            mul_en_q    <= mul_en_d;
            mul_otreg_q <= mul_otreg_d;
            mul_dtsts_q <= mul_dtsts_d;
            mul_cls_q   <= mul_cls_d;
            shf_en_q    <= shf_en_d;
            shf_cls_q   <= shf_cls_d;
            mv_q        <= mv_d;
            mn_q        <= mn_d;
            sv_q        <= sv_d;
            sz_q        <= sz_d;
        end
    end

    // Next state; outputs are decoded for the state being entered so they register cleanly
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        in_ready_d  = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        xa_d        = '0;
        ya_d        = '0;
        wa_d        = '0;
        cuen_d      = '0;
        dmen_d      = 1'b0;
        mul_en_d    = 1'b0;
        mul_otreg_d = 1'b0;
        mul_dtsts_d = '0;
        mul_cls_d   = '0;
        shf_en_d    = 1'b0;
        shf_cls_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    instr_d = in_instr;
                    state_d = (in_unit == UNIT_DM) ? ST_WB : ST_EXEC;
                    case (in_unit)
                        UNIT_MUL: cnt_d = CNT_W'(MUL_LAT - 1);
                        UNIT_SHF: cnt_d = CNT_W'(SHF_LAT - 1);
                        default:  cnt_d = '0;
                    endcase
                end
            end
            ST_EXEC: state_d = (cnt_q == '0) ? ST_WB : ST_WAIT;
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = ST_WB;
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);

        if (state_d != ST_IDLE && unit_d != UNIT_DM) begin
            xa_d = instr_d[RX_LSB +: AW];
            ya_d = instr_d[RY_LSB +: AW];
        end

        if (state_d == ST_EXEC) begin
            if (unit_d == UNIT_MUL) begin
                mul_en_d    = 1'b1;
                mul_cls_d   = instr_d[CLS_LSB +: 2];
                mul_dtsts_d = instr_d[DTSTS_LSB +: 4];
                mul_otreg_d = instr_d[OTREG_BIT];
            end
            if (unit_d == UNIT_SHF) begin
                shf_en_d  = 1'b1;
                shf_cls_d = instr_d[CLS_LSB +: 2];
            end
        end

        if (state_d == ST_WB) begin
            wa_d   = instr_d[RN_LSB +: AW];
            done_d = 1'b1;
            case (unit_d)
                UNIT_ALU: cuen_d = SW'(1);
                UNIT_MUL: cuen_d = SW'(2);
                UNIT_SHF: cuen_d = SW'(4);
                default:  dmen_d = 1'b1;
            endcase
        end
    end

    // Sticky flags: clear first, then a writeback-cycle set overrides the clear
    always_comb begin
        mv_d = (clr_flags ? 1'b0 : mv_q);
        mn_d = (clr_flags ? 1'b0 : mn_q);
        sv_d = (clr_flags ? 1'b0 : sv_q);
        sz_d = (clr_flags ? 1'b0 : sz_q);
        if (state_q == ST_WB && unit_q == UNIT_MUL) begin
            mv_d = mv_d | mul_ps_ov;
            mn_d = mn_d | mul_ps_mn;
        end
        if (state_q == ST_WB && unit_q == UNIT_SHF) begin
            sv_d = sv_d | shf_ovflag;
            sz_d = sz_d | shf_zeroflag;
        end
    end

    assign in_ready     = in_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign ps_rf_xA     = xa_q;
    assign ps_rf_yA     = ya_q;
    assign ps_rf_wrtA   = wa_q;
    assign ps_xb_cuEn   = cuen_q;
    assign ps_xb_dmEn   = dmen_q;
    assign ps_mul_en    = mul_en_q;
    assign ps_mul_otreg = mul_otreg_q;
    assign ps_mul_dtsts = mul_dtsts_q;
    assign ps_mul_cls   = mul_cls_q;
    assign ps_shf_en    = shf_en_q;
    assign ps_shf_cls   = shf_cls_q;
    assign sts_mv       = mv_q;
    assign sts_mn       = mn_q;
    assign sts_sv       = sv_q;
    assign sts_sz       = sz_q;

endmodule

// File: tb/tb_ps_cu_issue.sv
// Directed bench for ps_cu_issue with hand-computed expected values.
module tb_ps_cu_issue;

    localparam int unsigned AW      = 4;
    localparam int unsigned SW      = 3;
    localparam int unsigned INSTR_W = 9 + 3 * AW;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               clr_flags;
    logic [AW-1:0]      ps_rf_xA, ps_rf_yA, ps_rf_wrtA;
    logic [SW-1:0]      ps_xb_cuEn;
    logic               ps_xb_dmEn;
    logic               ps_mul_en, ps_mul_otreg;
    logic [3:0]         ps_mul_dtsts;
    logic [1:0]         ps_mul_cls;
    logic               ps_shf_en;
    logic [1:0]         ps_shf_cls;
    logic               mul_ps_ov, mul_ps_mn, shf_ovflag, shf_zeroflag;
    logic               sts_mv, sts_mn, sts_sv, sts_sz;
    logic               busy, done;

    int n_vec = 0;
    int n_bad = 0;

    ps_cu_issue #(.ADDRESS_WIDTH(4), .SIGNAL_WIDTH(3), .MUL_LAT(2), .SHF_LAT(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .clr_flags(clr_flags),
        .ps_rf_xA(ps_rf_xA), .ps_rf_yA(ps_rf_yA), .ps_rf_wrtA(ps_rf_wrtA),
        .ps_xb_cuEn(ps_xb_cuEn), .ps_xb_dmEn(ps_xb_dmEn),
        .ps_mul_en(ps_mul_en), .ps_mul_otreg(ps_mul_otreg),
        .ps_mul_dtsts(ps_mul_dtsts), .ps_mul_cls(ps_mul_cls),
        .ps_shf_en(ps_shf_en), .ps_shf_cls(ps_shf_cls),
        .mul_ps_ov(mul_ps_ov), .mul_ps_mn(mul_ps_mn),
        .shf_ovflag(shf_ovflag), .shf_zeroflag(shf_zeroflag),
        .sts_mv(sts_mv), .sts_mn(sts_mn), .sts_sv(sts_sv), .sts_sz(sts_sz),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [INSTR_W-1:0] mk(input logic [1:0] unit, input logic [1:0] cls,
                                              input logic [3:0] dtsts, input logic otreg,
                                              input logic [3:0] rn, input logic [3:0] rx,
                                              input logic [3:0] ry);
        mk = {unit, cls, dtsts, otreg, rn, rx, ry};
    endfunction

    initial begin
        reset = 1'b1; in_valid = 1'b1; in_instr = mk(2'b01, 2'b01, 4'hF, 1'b1, 4'd7, 4'd7, 4'd7);
        clr_flags = 1'b0; mul_ps_ov = 1'b0; mul_ps_mn = 1'b0; shf_ovflag = 1'b0; shf_zeroflag = 1'b0;

        // 1: reset held two cycles with in_valid high
        tick(); tick();
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mul_en", 32'(ps_mul_en), 32'd0);
        chk("rst_cuen", 32'(ps_xb_cuEn), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        in_valid = 1'b0; reset = 1'b0;
        tick();
        chk("rst_post_ready", 32'(in_ready), 32'd1);
        chk("rst_sts", 32'({sts_mv, sts_mn, sts_sv, sts_sz}), 32'd0);

        // 2: ALU rn=5 rx=1 ry=2
        in_valid = 1'b1; in_instr = mk(2'b00, 2'b00, 4'h0, 1'b0, 4'd5, 4'd1, 4'd2);
        tick(); in_valid = 1'b0;
        chk("alu_xa", 32'(ps_rf_xA), 32'd1);
        chk("alu_ya", 32'(ps_rf_yA), 32'd2);
        chk("alu_exec_ready", 32'(in_ready), 32'd0);
        chk("alu_exec_en", 32'({ps_mul_en, ps_shf_en}), 32'd0);
        tick();
        chk("alu_cuen", 32'(ps_xb_cuEn), 32'b001);
        chk("alu_wrta", 32'(ps_rf_wrtA), 32'd5);
        chk("alu_done", 32'(done), 32'd1);
        tick();
        chk("alu_ready", 32'(in_ready), 32'd1);
        chk("alu_done_low", 32'(done), 32'd0);

        // 3: MUL dtsts=1010 cls=01 otreg=1, ov at writeback
        in_valid = 1'b1; in_instr = mk(2'b01, 2'b01, 4'b1010, 1'b1, 4'd3, 4'd4, 4'd6);
        tick(); in_valid = 1'b0;
        chk("mul_en", 32'(ps_mul_en), 32'd1);
        chk("mul_fields", 32'({ps_mul_cls, ps_mul_dtsts, ps_mul_otreg}), 32'b01_1010_1);
        chk("mul_xa", 32'(ps_rf_xA), 32'd4);
        tick();
        chk("mul_en_pulse", 32'(ps_mul_en), 32'd0);
        chk("mul_wait_cuen", 32'(ps_xb_cuEn), 32'd0);
        chk("mul_wait_ya", 32'(ps_rf_yA), 32'd6);
        mul_ps_ov = 1'b1;
        tick();
        chk("mul_cuen", 32'(ps_xb_cuEn), 32'b010);
        chk("mul_done", 32'(done), 32'd1);
        chk("mul_wrta", 32'(ps_rf_wrtA), 32'd3);
        tick(); mul_ps_ov = 1'b0;
        chk("mul_sts", 32'({sts_mv, sts_mn, sts_sv, sts_sz}), 32'b1000);
        chk("mul_ready", 32'(in_ready), 32'd1);

        // 4: DM load rn=15, SHF offered back-to-back
        in_valid = 1'b1; in_instr = mk(2'b11, 2'b00, 4'h0, 1'b0, 4'd15, 4'd0, 4'd0);
        tick();
        in_instr = mk(2'b10, 2'b10, 4'h0, 1'b0, 4'd9, 4'd8, 4'd10);
        chk("dm_dmen", 32'(ps_xb_dmEn), 32'd1);
        chk("dm_wrta", 32'(ps_rf_wrtA), 32'd15);
        chk("dm_cuen", 32'(ps_xb_cuEn), 32'd0);
        chk("dm_done", 32'(done), 32'd1);
        chk("dm_ready", 32'(in_ready), 32'd0);
        tick();
        chk("dm_t2_ready", 32'(in_ready), 32'd1);
        chk("dm_t2_dmen", 32'(ps_xb_dmEn), 32'd0);
        chk("dm_sts", 32'({sts_mv, sts_mn, sts_sv, sts_sz}), 32'b1000);
        tick(); in_valid = 1'b0;
        chk("shf_en", 32'(ps_shf_en), 32'd1);
        chk("shf_cls", 32'(ps_shf_cls), 32'b10);
        chk("shf_xa", 32'(ps_rf_xA), 32'd8);

        // 5: clr_flags coincident with SHF writeback zeroflag, then alone
        tick();
        chk("shf_cuen", 32'(ps_xb_cuEn), 32'b100);
        chk("shf_wrta", 32'(ps_rf_wrtA), 32'd9);
        chk("shf_en_low", 32'(ps_shf_en), 32'd0);
        clr_flags = 1'b1; shf_zeroflag = 1'b1;
        tick(); shf_zeroflag = 1'b0;
        chk("clr_set_wins", 32'({sts_mv, sts_mn, sts_sv, sts_sz}), 32'b0001);
        tick(); clr_flags = 1'b0;
        chk("clr_alone", 32'({sts_mv, sts_mn, sts_sv, sts_sz}), 32'b0000);

        // 6: reset during MUL wait aborts the instruction
        in_valid = 1'b1; in_instr = mk(2'b01, 2'b00, 4'h3, 1'b0, 4'd2, 4'd1, 4'd1);
        tick(); in_valid = 1'b0;
        tick();
        chk("abort_in_wait", 32'(busy), 32'd1);
        reset = 1'b1; mul_ps_ov = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_wb", 32'({ps_xb_cuEn, done}), 32'd0);
            tick();
        end
        mul_ps_ov = 1'b0;
        chk("abort_sts", 32'({sts_mv, sts_mn, sts_sv, sts_sz}), 32'd0);
        chk("abort_ready_end", 32'(in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
